led_fade_driver: RTL and testbench
==================================

# led_fade_driver

Soft-fade LED driver that sits directly downstream of the Avalon PIO LED output port. It takes the PIO's per-LED on/off levels and drives the board LED pins. Each channel ramps its brightness up or down through a PWM duty-cycle fade instead of switching hard. It is fully synchronous to the Avalon system clock, so no CDC is needed on the PIO outputs.

## Interface
- NUM_LEDS, 2, number of independent channels; matches PIO width
- TICK_DIV, 50000, clk cycles per fade tick; 1 kHz at 50 MHz
- PWM_BITS, 4, PWM resolution; MAX = 2^PWM_BITS-1
- STEP_TICKS, 16, ticks per brightness step
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- led_in  in  NUM_LEDS  requested LED level from the PIO out_port; 1 = on
- led_out  out  NUM_LEDS  PWM-modulated LED drive; 1 = lit
- busy  out  NUM_LEDS  channel is fading (RISE or FALL)

## Operation
- Input register: led_in is sampled once into led_q. The FSM uses only led_q.
- Prescaler: free-running counter, 0..TICK_DIV-1, shared by all channels.
  - tick pulses for 1 cycle when the counter equals TICK_DIV-1.
  - The counter then wraps to 0.
- PWM counter: pwm_cnt is PWM_BITS wide, increments every clk, and wraps MAX->0. It is shared by all channels.
- Per channel i, the state is one of OFF, RISE, ON, FALL, plus:
  - level[i], 0..MAX
  - step_cnt[i], 0..STEP_TICKS-1
- Transitions, evaluated every cycle:
  - OFF: led_q=1 -> RISE.
  - RISE: led_q=0 -> FALL, with level held. Otherwise, on a step event, level+1. If the new level is MAX -> ON.
  - ON: led_q=0 -> FALL.
  - FALL: led_q=1 -> RISE, with level held. Otherwise, on a step event, level-1. If the new level is 0 -> OFF.
- Step event: tick=1 and step_cnt=STEP_TICKS-1. step_cnt then returns to 0. On other ticks in RISE/FALL, step_cnt increments.
- step_cnt clears to 0 on every state change and holds 0 in OFF/ON.
- Saturation:
  - level never exceeds MAX and never goes below 0.
  - A RISE entered at MAX goes to ON on its first step event, with no increment past MAX. The same rule applies to a FALL entered at 0.
- Drive function:
  - led_out[i] is registered.
  - When level=MAX, led_out[i] = 1.
  - Otherwise, led_out[i] = (level[i] > pwm_cnt).
  - So level 0 is always dark, MAX is always lit, and level k is lit k of every 2^PWM_BITS cycles.
- busy[i] is registered and equals (state is RISE or FALL).
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Reset, when asserted on any cycle including mid-fade, clears all of these on the next clk edge:
  - prescaler, pwm_cnt, led_q
  - all state to OFF
  - level and step_cnt
  - led_out=0 and busy=0

## Timing
- led_in change -> led_q: 1 cycle.
- led_q change -> state change: 1 cycle.
- State change -> busy: 1 cycle.
- Total led_in to busy: 3 cycles.
- level change -> led_out reflects it: 1 cycle.
- Per-step duration: the first step after a state entry takes (STEP_TICKS-1)*TICK_DIV+1 to STEP_TICKS*TICK_DIV cycles, depending on prescaler phase. Later steps take exactly STEP_TICKS*TICK_DIV cycles.
- Full fade 0->MAX: MAX steps; at defaults about 240 ms.
- A direction reversal takes effect 2 cycles after the led_in edge; level is not lost.

## Test plan
All scenarios use TICK_DIV=4, STEP_TICKS=2, PWM_BITS=2, so MAX=3.
- Reset:
  - Stimulus: hold reset 3 cycles with led_in=2'b11.
  - Response: led_out=0 and busy=0 throughout. A channel mid-RISE at level 2 returns to level 0 / OFF one edge after reset is asserted.
- Full rise, ch0:
  - Stimulus: led_in=2'b01 held.
  - Response: busy[0]=1 three cycles after the edge. level goes 1,2,3, with steps after 5..8, then exactly 8, then exactly 8 cycles. busy[0] falls when ON is reached. led_out[0] is then constant 1. led_out[1]=0 throughout.
- Duty check:
  - Stimulus: freeze a channel at level 1 (reverse at the right step, or force).
  - Response: led_out high exactly 1 of every 4 cycles. At level 2: 2 of 4 cycles.
- Mid-rise reversal:
  - Stimulus: led_in[0]=1, then back to 0 after level reaches 2.
  - Response: state goes FALL with level 2 kept. Level goes 2->1->0 at 8-cycle step spacing after the first step. State reaches OFF with led_out[0]=0.
- Simultaneous channels:
  - Stimulus: ch1 ON while ch0 OFF; in the same cycle set led_in=2'b01.
  - Response: ch0 goes RISE and ch1 goes FALL in the same cycle. busy=2'b11 three cycles later. Both reach their end states on identical step-event cycles, because the prescaler is shared.
- Reset mid-fade:
  - Stimulus: assert reset during FALL at level 2, then release with led_in=2'b00.
  - Response: level 0 / OFF, led_out=0, busy=0. No activity afterwards.

Source files
------------

// File: rtl/led_fade_driver.sv
// Soft-fade LED driver: per-channel PWM brightness ramps
// between off and on, driven from PIO on/off levels.
module led_fade_driver #(
  parameter int NUM_LEDS   = 2,
  parameter int TICK_DIV   = 50000,
  parameter int PWM_BITS   = 4,
  parameter int STEP_TICKS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [NUM_LEDS-1:0] busy
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - 1'b1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  logic [NUM_LEDS-1:0] led_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  state_t              state    [NUM_LEDS];
  logic [PWM_BITS-1:0] level    [NUM_LEDS];
  logic [STEP_W-1:0]   step_cnt [NUM_LEDS];

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      led_q   <= led_in;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // All channels share tick and pwm_cnt, so their steps stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
      busy    <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        state[i]    <= OFF;
        level[i]    <= '0;
        step_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_out[i] <= (level[i] == MAX) ||
                      (level[i] > pwm_cnt);
        busy[i]    <= (state[i] == RISE) ||
                      (state[i] == FALL);
        unique case (state[i])
          OFF: begin
            if (led_q[i]) begin
              state[i]    <= RISE;
              step_cnt[i] <= '0;
            end
          end
          RISE: begin
            if (!led_q[i]) begin
              state[i]    <= FALL;
              step_cnt[i] <= '0;
            end else if (tick && step_cnt[i] == STEP_LAST) begin
              step_cnt[i] <= '0;
              if (level[i] == MAX) begin
                state[i] <= ON;
              end else begin
                level[i] <= level[i] + 1'b1;
                if (level[i] == MAX_M1)
                  state[i] <= ON;
              end
            end else if (tick) begin
              step_cnt[i] <= step_cnt[i] + 1'b1;
            end
          end
          ON: begin
            if (!led_q[i]) begin
              state[i]    <= FALL;
              step_cnt[i] <= '0;
            end
          end
          FALL: begin
            if (led_q[i]) begin
              state[i]    <= RISE;
              step_cnt[i] <= '0;
            end else if (tick && step_cnt[i] == STEP_LAST) begin
              step_cnt[i] <= '0;
              if (level[i] == '0) begin
                state[i] <= OFF;
              end else begin
                level[i] <= level[i] - 1'b1;
                if (level[i] == 1)
                  state[i] <= OFF;
              end
            end else if (tick) begin
              step_cnt[i] <= step_cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i]    <= OFF;
            step_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with small parameters
// (TICK_DIV=4, STEP_TICKS=2, PWM_BITS=2, MAX=3).
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] led_in;
  logic [1:0] led_out;
  logic [1:0] busy;

  int total = 0;
  int bad = 0;
  int n;
  int hits;
  int act;
  bit track1 = 1'b0;
  int l1_hits = 0;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_LEDS(2),
    .TICK_DIV(4),
    .PWM_BITS(2),
    .STEP_TICKS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .led_in(led_in),
    .led_out(led_out),
    .busy(busy)
  );

  always @(negedge clk)
    if (track1 && led_out[1] !== 1'b0) l1_hits++;

  task automatic chk(input string tag, input int got,
                     input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Advance until level[ch]==tgt; count edges from n0, 999 on timeout.
  task automatic wait_level(input int ch, input int tgt,
                            input int n0, output int nout);
    int c = n0;
    while (int'(dut.level[ch]) != tgt && c < n0 + 40) begin
      cyc();
      c++;
    end
    nout = (int'(dut.level[ch]) == tgt) ? c : 999;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    cyc(3);
    while (busy != 2'b00 && c < 80) begin
      cyc();
      c++;
    end
    chk(tag, int'(busy), 0);
  endtask

  initial begin
    reset  = 1'b1;
    led_in = 2'b11;

    // reset held 3 cycles
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_out", int'(led_out), 0);
      chk("rst_busy", int'(busy), 0);
    end
    chk("rst_lvl", int'(dut.level[0]), 0);
    reset  = 1'b0;
    led_in = 2'b00;
    cyc(2);

    // full rise on ch0
    track1 = 1'b1;
    led_in = 2'b01;
    cyc(2);
    chk("busy_lat2", int'(busy), 0);
    cyc();
    chk("busy_lat3", int'(busy), 1);
    wait_level(0, 1, 1, n);
    chk("step1_win", int'(n >= 5 && n <= 8), 1);
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      hits += int'(led_out[0]);
    end
    chk("duty_l1", hits, 1);
    wait_level(0, 2, 4, n);
    chk("step2", n, 8);
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      hits += int'(led_out[0]);
    end
    chk("duty_l2", hits, 2);
    wait_level(0, 3, 4, n);
    chk("step3", n, 8);
    chk("busy_pre_on", int'(busy[0]), 1);
    cyc();
    chk("busy_on", int'(busy[0]), 0);
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      hits += int'(led_out[0]);
    end
    chk("on_lit", hits, 8);
    track1 = 1'b0;
    chk("ch1_dark", l1_hits, 0);

    // swap: ch0 falls, ch1 rises together
    led_in = 2'b10;
    wait_idle("swap_idle");
    chk("swap_l0", int'(dut.level[0]), 0);
    chk("swap_l1", int'(dut.level[1]), 3);
    cyc();
    chk("swap_out", int'(led_out), 2);

    // simultaneous opposite fades
    led_in = 2'b01;
    cyc(2);
    chk("sim_lat2", int'(busy), 0);
    cyc();
    chk("sim_lat3", int'(busy), 3);
    wait_level(0, 3, 0, n);
    chk("sim_to", int'(n < 999), 1);
    chk("sim_l1", int'(dut.level[1]), 0);
    cyc();
    chk("sim_idle", int'(busy), 0);
    cyc();
    chk("sim_out", int'(led_out), 1);

    // mid-rise reversal
    led_in = 2'b00;
    wait_idle("rev_off");
    chk("rev_l0", int'(dut.level[0]), 0);
    led_in = 2'b01;
    wait_level(0, 2, 0, n);
    chk("rev_to", int'(n < 999), 1);
    led_in = 2'b00;
    cyc(2);
    chk("rev_hold", int'(dut.level[0]), 2);
    chk("rev_busy", int'(busy[0]), 1);
    wait_level(0, 1, 0, n);
    chk("rev_win", int'(n >= 5 && n <= 8), 1);
    wait_level(0, 0, 0, n);
    chk("rev_step", n, 8);
    cyc();
    chk("rev_busy0", int'(busy[0]), 0);
    chk("rev_dark", int'(led_out[0]), 0);

    // reset mid-rise at level 2
    led_in = 2'b01;
    wait_level(0, 2, 0, n);
    chk("mr_to", int'(n < 999), 1);
    reset  = 1'b1;
    led_in = 2'b11;
    cyc();
    chk("mr_lvl", int'(dut.level[0]), 0);
    act = 0;
    for (int k = 0; k < 3; k++) begin
      if (led_out != 2'b00 || busy != 2'b00) act++;
      if (k < 2) cyc();
    end
    chk("mr_quiet", act, 0);
    reset  = 1'b0;
    led_in = 2'b00;
    cyc(2);

    // reset mid-fall at level 2
    led_in = 2'b01;
    wait_idle("mf_on");
    chk("mf_l3", int'(dut.level[0]), 3);
    led_in = 2'b00;
    wait_level(0, 2, 0, n);
    chk("mf_to", int'(n < 999), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mf_lvl", int'(dut.level[0]), 0);
    act = 0;
    for (int k = 0; k < 40; k++) begin
      if (led_out != 2'b00 || busy != 2'b00 ||
          dut.level[0] != 2'd0) act++;
      cyc();
    end
    chk("mf_quiet", act, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
